// File: rtl/uart_pkg.sv
// Shared UART receiver constants: legal per-bit sample counts and the fallback
// configuration used when prescale/num_samples are out of range.
package uart_pkg;

  localparam logic [2:0] SAMPLES_1 = 3'd1;
  localparam logic [2:0] SAMPLES_3 = 3'd3;
  localparam logic [2:0] SAMPLES_5 = 3'd5;

  localparam int unsigned DEFAULT_PRESCALE = 8;
  localparam int unsigned MIN_PRESCALE     = 4;
  localparam logic [2:0]  DEFAULT_SAMPLES  = SAMPLES_3;

  function automatic logic legal_samples(input logic [2:0] n);
    return (n == SAMPLES_1) || (n == SAMPLES_3) || (n == SAMPLES_5);
  endfunction

endpackage

// File: rtl/uart_majority_vote.sv
// Combinational majority vote and all-equal check over the first n samples.
// Zero latency, no flow control; the caller supplies the lane mask.
module uart_majority_vote #(
  parameter int MAX_SAMPLES = 5,
  parameter int CNT_W       = $clog2(MAX_SAMPLES + 1)
) (
  input  logic [MAX_SAMPLES-1:0] samples,
  input  logic [MAX_SAMPLES-1:0] mask,
  input  logic [CNT_W-1:0]       n,
  output logic                   majority,
  output logic                   noisy
);

  logic [CNT_W-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < MAX_SAMPLES; i++) begin
      ones = ones + CNT_W'(samples[i] & mask[i]);
    end
    majority = ones > (n >> 1);
    noisy    = (ones != '0) && (ones != n);
  end

endmodule

// File: rtl/data_sampling_mv.sv
// Oversampling bit sampler: captures 1/3/5 samples ending at mid-bit and majority-votes them.
// Valid one cycle after the last capture; no backpressure, a skipped/repeated edge or enable drop aborts.
module data_sampling_mv
  import uart_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int EDGE_W      = 6,
  parameter int MAX_SAMPLES = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  dat_samp_en,
  input  logic [EDGE_W-1:0]     edge_cnt,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [2:0]            num_samples,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err
);

  localparam int CNT_W = $clog2(MAX_SAMPLES + 1);

  logic                   pre_ok;
  logic [PRESCALE_W-1:0]  pre_eff;
  logic [EDGE_W-1:0]      half_eff, first_eff, first_l;
  logic [2:0]             req_n, n_eff, n_l, n_cur;
  logic                   active;
  logic [CNT_W-1:0]       cap_cnt;
  logic [MAX_SAMPLES-1:0] samp_q, samp_nxt, mask;
  logic                   open_win, capture, abort_win, done;
  logic                   vote_bit, vote_noisy;

  // Live config sanitising; only consulted when a window opens.
  always_comb begin
    pre_ok    = !prescale[0] && (prescale >= PRESCALE_W'(MIN_PRESCALE));
    pre_eff   = pre_ok ? prescale : PRESCALE_W'(DEFAULT_PRESCALE);
    half_eff  = EDGE_W'(pre_eff >> 1);
    req_n     = legal_samples(num_samples) ? num_samples : DEFAULT_SAMPLES;
    n_eff     = req_n;
    if (req_n == SAMPLES_5 && (half_eff < EDGE_W'(4) || MAX_SAMPLES < 5)) begin
      n_eff = SAMPLES_3;
    end
    first_eff = half_eff - EDGE_W'(n_eff - 3'd1);
  end

  always_comb begin
    open_win  = !active && dat_samp_en && (edge_cnt == first_eff);
    capture   = open_win ||
                (active && dat_samp_en && (edge_cnt == first_l + EDGE_W'(cap_cnt)));
    abort_win = active && !capture;
    n_cur     = active ? n_l : n_eff;
    done      = capture && (cap_cnt == CNT_W'(n_cur - 3'd1));
    samp_nxt  = samp_q;
    if (capture) begin
      samp_nxt[cap_cnt] = RX_IN;
    end
    for (int i = 0; i < MAX_SAMPLES; i++) begin
      mask[i] = (i < int'(n_cur));
    end
  end

  uart_majority_vote #(
    .MAX_SAMPLES(MAX_SAMPLES),
    .CNT_W      (CNT_W)
  ) u_vote (
    .samples (samp_nxt),
    .mask    (mask),
    .n       (CNT_W'(n_cur)),
    .majority(vote_bit),
    .noisy   (vote_noisy)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit  <= 1'b0;
      sample_valid <= 1'b0;
      noise_err    <= 1'b0;
      active       <= 1'b0;
      cap_cnt      <= '0;
      samp_q       <= '0;
      n_l          <= DEFAULT_SAMPLES;
      first_l      <= '0;
    end else begin
      sample_valid <= done;
      if (done) begin
        sampled_bit <= vote_bit;
        noise_err   <= vote_noisy;
      end
      if (open_win) begin
        n_l     <= n_eff;
        first_l <= first_eff;
      end
      if (done || abort_win) begin
        active  <= 1'b0;
        cap_cnt <= '0;
        samp_q  <= '0;
      end else if (capture) begin
        active  <= 1'b1;
        cap_cnt <= cap_cnt + CNT_W'(1);
        samp_q  <= samp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_data_sampling_mv.sv
// Scoreboard bench for data_sampling_mv: expected votes queued at the last capture edge,
// popped and compared (value and cycle) when sample_valid is seen.
module tb_data_sampling_mv;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       dat_samp_en = 1'b0;
  logic [5:0] edge_cnt = '0;
  logic       RX_IN = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [2:0] num_samples = 3'd3;
  logic       sampled_bit, sample_valid, noise_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic last_b  = 1'b0;
  logic last_nz = 1'b0;

  typedef struct {
    logic b;
    logic nz;
    int   cyc;
  } exp_t;
  exp_t sb[$];

  data_sampling_mv dut (
    .CLK         (CLK),
    .RST         (RST),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .RX_IN       (RX_IN),
    .prescale    (prescale),
    .num_samples (num_samples),
    .sampled_bit (sampled_bit),
    .sample_valid(sample_valid),
    .noise_err   (noise_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    exp_t e;
    if (RST && sample_valid !== 1'b0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid cyc=%0d got valid=%b want no valid", cyc, sample_valid);
      end else begin
        e = sb.pop_front();
        if (sampled_bit !== e.b || noise_err !== e.nz || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL valid_result got bit=%b noise=%b cyc=%0d want bit=%b noise=%b cyc=%0d",
                   sampled_bit, noise_err, cyc, e.b, e.nz, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want test completion");
    $fatal(1, "watchdog");
  end

  // One bit period: edges 0..len-1, window samples bits[0..n-1] at edges first..first+n-1.
  task automatic drive_bit(input int pre_in, input int num_in, input int len, input int first,
                           input int n, input logic [4:0] bits, input logic outside,
                           input int drop_at, input bit exp_valid, input int chg_at,
                           input int chg_pre);
    int   ones;
    exp_t e;
    for (int k = 0; k < len; k++) begin
      @(posedge CLK); #1;
      edge_cnt    = 6'(k);
      num_samples = 3'(num_in);
      prescale    = (chg_at >= 0 && k >= chg_at) ? 6'(chg_pre) : 6'(pre_in);
      dat_samp_en = (drop_at < 0) || (k < drop_at);
      RX_IN       = (k >= first && k < first + n) ? bits[k - first] : outside;
      if (exp_valid && k == first + n - 1) begin
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(bits[i]);
        e.b   = (ones > n / 2);
        e.nz  = (ones != 0) && (ones != n);
        e.cyc = cyc + 1;
        last_b  = e.b;
        last_nz = e.nz;
        sb.push_back(e);
      end
    end
  endtask

  task automatic settle(input string name);
    @(posedge CLK); #1;
    dat_samp_en = 1'b0;
    edge_cnt    = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending got %0d outstanding want 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({sampled_bit, sample_valid, noise_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 000", {sampled_bit, sample_valid, noise_err});
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if ({sampled_bit, sample_valid, noise_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release got %b want 000", {sampled_bit, sample_valid, noise_err});
    end
  endtask

  task automatic test_p8_n3();
    drive_bit(8, 3, 8, 2, 3, 5'b00101, 1'b0, -1, 1, -1, 0);
    drive_bit(8, 3, 8, 2, 3, 5'b00000, 1'b1, -1, 1, -1, 0);
    drive_bit(8, 3, 8, 2, 3, 5'b00011, 1'b0, -1, 1, -1, 0);
    settle("p8_n3");
  endtask

  task automatic test_p16_n5();
    drive_bit(16, 5, 16, 4, 5, 5'b00100, 1'b1, -1, 1, -1, 0);
    drive_bit(16, 5, 16, 4, 5, 5'b11111, 1'b0, -1, 1, -1, 0);
    drive_bit(16, 5, 16, 4, 5, 5'b01011, 1'b0, -1, 1, -1, 0);
    settle("p16_n5");
  endtask

  task automatic test_sanitise();
    drive_bit(4, 5, 4, 0, 3, 5'b00011, 1'b0, -1, 1, -1, 0);  // N reduced to 3
    drive_bit(6, 5, 6, 1, 3, 5'b00110, 1'b0, -1, 1, -1, 0);  // half=3 too small for 5
    drive_bit(7, 3, 8, 2, 3, 5'b00101, 1'b0, -1, 1, -1, 0);  // odd prescale -> 8
    drive_bit(2, 3, 8, 2, 3, 5'b00110, 1'b0, -1, 1, -1, 0);  // too small -> 8
    drive_bit(8, 2, 8, 2, 3, 5'b00001, 1'b1, -1, 1, -1, 0);  // illegal N -> 3
    drive_bit(8, 1, 8, 4, 1, 5'b00001, 1'b0, -1, 1, -1, 0);  // single sample at mid-bit
    drive_bit(8, 1, 8, 4, 1, 5'b00000, 1'b1, -1, 1, -1, 0);
    settle("sanitise");
  endtask

  task automatic test_enable_drop();
    drive_bit(8, 3, 8, 2, 3, 5'b00111, 1'b0, -1, 1, -1, 0);
    drive_bit(8, 3, 8, 2, 3, 5'b00000, 1'b0, 3, 0, -1, 0);
    settle("drop");
    n_checks++;
    if (sampled_bit !== last_b || noise_err !== last_nz) begin
      n_fail++;
      $display("FAIL drop_hold got bit=%b noise=%b want bit=%b noise=%b",
               sampled_bit, noise_err, last_b, last_nz);
    end
    drive_bit(8, 3, 8, 2, 3, 5'b00010, 1'b1, -1, 1, -1, 0);
    settle("drop_next");
  endtask

  task automatic test_reset_mid();
    drive_bit(16, 3, 16, 6, 3, 5'b00111, 1'b0, -1, 1, -1, 0);
    for (int k = 0; k <= 6; k++) begin
      @(posedge CLK); #1;
      edge_cnt    = 6'(k);
      dat_samp_en = 1'b1;
      RX_IN       = 1'b1;
    end
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    n_checks++;
    if ({sampled_bit, sample_valid, noise_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid got %b want 000", {sampled_bit, sample_valid, noise_err});
    end
    edge_cnt = 6'd7;
    @(posedge CLK); #1;
    RST = 1'b1;
    for (int k = 8; k < 16; k++) begin
      edge_cnt = 6'(k);
      @(posedge CLK); #1;
    end
    n_checks++;
    if (sampled_bit !== 1'b0 || noise_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_hold got bit=%b noise=%b want 0 0", sampled_bit, noise_err);
    end
    drive_bit(16, 3, 16, 6, 3, 5'b00110, 1'b0, -1, 1, -1, 0);
    settle("reset_mid");
  endtask

  task automatic test_prescale_change();
    // Latched prescale=8 finishes at edge 4; the stray window at 6,7 aborts on wrap.
    drive_bit(8, 3, 8, 2, 3, 5'b00101, 1'b0, -1, 1, 3, 16);
    drive_bit(16, 3, 16, 6, 3, 5'b00011, 1'b0, -1, 1, -1, 0);
    settle("prescale_chg");
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 8; b++) begin
      drive_bit(4, 3, 4, 0, 3, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                -1, 1, -1, 0);
    end
    settle("back_to_back");
  endtask

  initial begin
    test_reset();
    test_p8_n3();
    test_p16_n5();
    test_sanitise();
    test_enable_drop();
    test_reset_mid();
    test_prescale_change();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sampling_mv.md
Name: data_sampling_mv

Overview:
Parametrised oversampling bit sampler for the UART receiver, replacing the fixed 3-sample, 4/8/16/32-only sampler.
- Captures 1, 3 or 5 consecutive oversampled values of RX_IN, ending at the mid-bit edge for any legal even prescale.
- Majority-votes the captured samples and reports the result with a one-cycle valid strobe and a noise flag.
- Sits between the edge/bit counter and the start/parity/stop checkers and deserializer.

Parameters:
- PRESCALE_W, 6, width of prescale input.
- EDGE_W, 6, width of edge_cnt input (must be >= PRESCALE_W).
- MAX_SAMPLES, 5, maximum samples per bit (odd, >= 3).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous reset, active-low.
- dat_samp_en  input  1  sampling enable from the FSM; low aborts the current window.
- edge_cnt  input  EDGE_W  oversample edge index within the current bit, 0..prescale-1.
- RX_IN  input  1  serial line, already synchronised.
- prescale  input  PRESCALE_W  oversampling ratio.
- num_samples  input  3  requested samples per bit: 1, 3 or 5.
- sampled_bit  output  1  registered majority result of the last completed window.
- sample_valid  output  1  one-cycle pulse; sampled_bit/noise_err updated this cycle.
- noise_err  output  1  registered; the last window's samples were not all equal.

Behaviour:
- Reset (RST low, async): sampled_bit=0, sample_valid=0, noise_err=0; sample register, ones counter and capture counter cleared; window inactive.
- Config sanitising (combinational):
  - prescale odd or <4 is treated as 8.
  - num_samples not in {1,3,5} is treated as 3.
  - Effective N = requested value, reduced to the largest legal odd value with N-1 <= prescale/2 (prescale=4, N=5 gives N=3).
- Window: last = prescale>>1; first = last-(N-1).
  - prescale=8, N=3: edges 2,3,4. prescale=16, N=5: edges 4..8. prescale=4, N=3: edges 0,1,2.
- Config latch: prescale and N are latched on the cycle edge_cnt==first with dat_samp_en=1, which opens the window. Changes to prescale or num_samples mid-window are ignored until the next window.
- Capture: each cycle with dat_samp_en=1 and edge_cnt == first+capture_cnt:
  - store RX_IN;
  - increment capture_cnt;
  - increment ones_cnt if RX_IN=1.
- Edge_cnt outside the expected next index while the window is open (skip or repeat): the window aborts, counters clear, and no valid is produced.
- Completion: on the cycle the Nth sample is captured (edge_cnt==last), the following clock edge:
  - sampled_bit <= (ones_cnt_final > N>>1);
  - noise_err <= (ones_cnt_final != 0 && ones_cnt_final != N);
  - sample_valid <= 1 for exactly one cycle.
- Latency: last capture edge to valid = 1 cycle.
- N=1: the single sample at edge prescale/2; noise_err is always 0.
- Hold: sampled_bit and noise_err hold their values between windows. sample_valid is 0 except on the completion cycle.
- dat_samp_en falling mid-window: partial samples are discarded and no valid is produced. Outputs keep their previous values.
- Reset mid-window: everything clears immediately; no valid is produced.
- Back-to-back bits: a new window may open on the cycle immediately after the valid pulse.
- Widths: ones_cnt and capture_cnt are $clog2(MAX_SAMPLES+1) bits; window arithmetic uses EDGE_W bits with no wrap (first >= 0 is guaranteed by the N reduction).

Decomposition:
- Shared package uart_pkg:
  - legal sample counts (SAMPLES_1/3/5);
  - DEFAULT_PRESCALE=8;
  - MIN_PRESCALE=4;
  - DEFAULT_SAMPLES=3.
- One natural sub-module, uart_majority_vote: a combinational popcount-threshold and all-equal check over a MAX_SAMPLES vector with an N mask. It is reusable by start-bit glitch filtering.

Test Plan:
- prescale=8, N=3, RX_IN=1,0,1 at edges 2,3,4 -> valid pulse one cycle after edge 4, sampled_bit=1, noise_err=1.
- prescale=16, N=5, RX_IN=0,0,1,0,0 at edges 4..8 -> sampled_bit=0, noise_err=1; an all-ones window -> sampled_bit=1, noise_err=0.
- prescale=4, num_samples=5 -> N reduced to 3, capture at edges 0,1,2; prescale=7 -> behaves as 8 (edges 2,3,4); num_samples=2 -> behaves as 3.
- dat_samp_en dropped at edge 3 (prescale=8) -> no valid; sampled_bit retains prior value. Next full window produces a correct valid.
- RST asserted between edges 6 and 7 (prescale=16, N=3) -> outputs 0 immediately, no valid after release until a complete new window.
- prescale changed 8->16 at edge 3 -> window completes at edge 4 using prescale=8; the next bit uses edges 6,7,8.
